// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter: two line buffers feed a 3x3 window and give one result per interior pixel.
// Latency: one registered stage after the completing accept. There is no backpressure, and data_valid gaps only stall the pipeline.
module sobel_stream #(
  parameter  int DW = 8,
  parameter  int W  = 640,
  parameter  int H  = 480,
  localparam int OW = DW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] Din,
  input  logic          data_valid,
  input  logic          sof,
  input  logic [1:0]    mode,
  output logic [OW-1:0] Dout,
  output logic          dout_valid,
  output logic          frame_done,
  output logic          frame_err,
  output logic          busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   win_q [0:2][0:2];
  logic [DW-1:0]   win_d [0:2][0:2];
  logic            win_vld_q, win_vld_d;
  logic            last_q, last_d;
  logic            err_pend_q, err_pend_d;
  logic [OW-1:0]   dout_q, dout_d;
  logic            dout_vld_q, dout_vld_d;
  logic            done_q, done_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;

  logic [DW-1:0]   lb1_mem [0:W-1];
  logic [DW-1:0]   lb2_mem [0:W-1];

  logic            take, new_frame;
  logic [CW-1:0]   cur_col;
  logic [RW-1:0]   cur_row;
  logic [DW-1:0]   rd1, rd2;
  logic signed [OW-1:0] gx, gy, ax, ay;
  logic [OW-1:0]   result;

  function automatic logic signed [OW-1:0] ext(input logic [DW-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  // A sof accept always restarts at (0,0), which is also how an early sof resyncs.
  assign take      = data_valid && (state_q == RUN || sof);
  assign new_frame = data_valid && sof;
  assign cur_col   = new_frame ? '0 : col_q;
  assign cur_row   = new_frame ? '0 : row_q;
  assign rd1       = lb1_mem[cur_col];
  assign rd2       = lb2_mem[cur_col];

  always_comb begin
    gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy = (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]))
       - (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]));
    ax = gx[OW-1] ? -gx : gx;
    ay = gy[OW-1] ? -gy : gy;
    case (mode_q)
      2'd0:    result = gx;
      2'd1:    result = gy;
      default: result = ax + ay;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    win_d       = win_q;
    win_vld_d   = 1'b0;
    last_d      = 1'b0;
    err_pend_d  = 1'b0;
    dout_vld_d  = win_vld_q;
    done_d      = win_vld_q && last_q;
    frame_err_d = err_pend_q;
    dout_d      = win_vld_q ? result : dout_q;
    busy_d      = busy_q;

    if (take) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd2;
      win_d[1][2] = rd1;
      win_d[2][2] = Din;

      win_vld_d  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      last_d     = (cur_row == RW'(H-1)) && (cur_col == CW'(W-1));
      err_pend_d = sof && (state_q == RUN);
      if (new_frame) mode_d = mode;

      if (cur_col == CW'(W-1)) begin
        col_d = '0;
        row_d = cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      state_d = last_d ? IDLE : RUN;
    end

    // busy drops with frame_done; a back-to-back sof on that same edge keeps it high.
    if (done_d)    busy_d = 1'b0;
    if (new_frame) busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (take) begin
      lb1_mem[cur_col] <= Din;
      lb2_mem[cur_col] <= rd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= '0;
      win_q       <= '{default: '0};
      win_vld_q   <= 1'b0;
      last_q      <= 1'b0;
      err_pend_q  <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      win_vld_q   <= win_vld_d;
      last_q      <= last_d;
      err_pend_q  <= err_pend_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign Dout       = dout_q;
  assign dout_valid = dout_vld_q;
  assign frame_done = done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Streaming, parametrised 3x3 Sobel edge filter for raster-order pixel input; an image of any size W x H is processed on the fly.
- Uses two internal line buffers and a 3x3 window register array instead of whole-frame storage.
- Selects per frame between Gx, Gy and |Gx|+|Gy| outputs, and produces one result per interior pixel.
- Sits between the pixel source (camera or frame reader) and downstream edge/threshold logic in the image pipeline.

Parameters:
- DW, 8, pixel width in bits (unsigned).
- W, 640, pixels per line (>= 3).
- H, 480, lines per frame (>= 3).
- Derived, not overridable: OW = DW+4, output width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- Din  in  DW  pixel, unsigned.
- data_valid  in  1  Din/sof qualifier; pixel accepted on any rising edge with data_valid=1.
- sof  in  1  start of frame, qualified by data_valid, marks pixel (0,0).
- mode  in  2  0=Gx, 1=Gy, 2=|Gx|+|Gy|, 3=same as 2; sampled on the sof accept.
- Dout  out  OW  result.
- dout_valid  out  1  one-cycle strobe per result.
- frame_done  out  1  one-cycle pulse coinciding with the last result of a frame.
- frame_err  out  1  one-cycle pulse on an early sof (resync).
- busy  out  1  high from the sof accept until frame_done.

Behaviour:
- Reset (rst=0, asynchronous): Dout=0, dout_valid=0, frame_done=0, frame_err=0, busy=0; state=IDLE; row/column counters=0; mode register=0. Line-buffer contents are don't-care. Reset mid-frame abandons the frame; the next frame must begin with sof.
- States:
  - IDLE: accepted pixels with sof=0 are ignored. An accept with sof=1 goes to RUN: the pixel is stored as (0,0), mode is latched, busy=1.
  - RUN: each accept writes the pixel at (row,col); col increments, wrapping W-1 -> 0 with row+1. Accept of (H-1,W-1) returns to IDLE and busy falls on the same edge as frame_done rises.
- No backpressure; data_valid gaps of any length are allowed. Window, counters and outputs advance only on accepts.
- Window: taps p[r][c], r,c in 0..2. Row 0 is the oldest line (from line buffer 2), row 2 is the current line. Column 2 is the newest pixel. Line buffers are W deep, one write and one read per accept at address col.
- Arithmetic: all terms zero-extended to OW and signed.
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p00 + 2*p01 + p02) - (p20 + 2*p21 + p22).
  - Mode 2: |Gx| + |Gy|, unsigned, max 8*(2^DW-1), fits OW with MSB 0.
  - Gx/Gy are two's complement in OW bits. No saturation is needed.
- Valid window: when the accepted pixel has row>=2 and col>=2, the window centred at (row-1,col-1) is complete. Exactly (W-2)*(H-2) results per frame, in raster order. Border pixels produce no output.
- Latency: the pixel is accepted at edge t and the window updates at t. Dout and dout_valid are registered at edge t+1 and held for one cycle. dout_valid=0 and Dout holds its last value otherwise.
- frame_done is asserted with the dout_valid of window (H-2,W-2).
- Early sof: sof=1 while in RUN and not at the expected (0,0) position pulses frame_err at t+1. Counters restart with this pixel as (0,0) and mode is re-latched. The partial frame's remaining outputs are dropped; frame_done is not pulsed for it.
- A sof accept on the cycle after the last pixel of a frame (back-to-back frames) is legal and gives no frame_err. An in-flight final result still emits at t+1.
- mode changes outside a sof accept have no effect on the current frame.

Test Plan:
- W=H=5, DW=8, mode=0, pixel=10*col, no gaps -> 9 dout_valid strobes, all Dout=80; frame_done with the 9th; busy low afterwards.
- Same image, mode=1 -> all Dout=0. Pixel=10*row, mode=1 -> all Dout=-80 (12'hFB0). Same row image, mode=2 -> all 80.
- W=6,H=4, left 3 columns 0, right 3 columns 255, mode=0 -> 8 results; per row Dout = 0,1020,1020,0. Mode=3 gives same values as mode=2 (1020 max). Checkerboard 0/255, mode 2 -> Dout=0 everywhere (Gx=Gy=0 by symmetry), no overflow.
- Random data_valid gaps (~50% duty) on a random 7x5 frame -> Dout sequence identical to the no-gap run. Each dout_valid exactly 1 cycle after its completing accept.
- sof re-asserted at pixel (2,3) of a 5x5 frame -> frame_err pulse. A full new frame then follows with 9 correct results and one frame_done; no stale outputs.
- rst pulled low mid-frame -> all outputs 0 immediately (asynchronous). After release, pixels without sof are ignored (busy=0, no dout_valid) until an sof.
